// File: rtl/conv_3_5_mac_acc.sv
// Convolution MAC accumulator: sums KERNEL_LEN signed products plus a scaled
// bias, then rounds, shifts, saturates to 16 bits and optionally applies ReLU.
module conv_3_5_mac_acc #(
    parameter int unsigned KERNEL_LEN = 25,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned RELU       = 1
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [IN_WIDTH-1:0] prod_din,
    input  logic                prod_valid,
    output logic                prod_ready,
    input  logic [15:0]         bias,
    output logic [15:0]         out_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sat
);

    localparam int unsigned CNT_W = $clog2(KERNEL_LEN);
    localparam int unsigned RND_W = ACC_WIDTH + 1;

    // One extra bit keeps the rounding add from wrapping near full scale.
    localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (SHIFT - 1));
    localparam logic signed [RND_W-1:0] MAXV = RND_W'(32767);
    localparam logic signed [RND_W-1:0] MINV = RND_W'(-32768);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [15:0]                 dout_q, dout_d;
    logic                        valid_q, valid_d;
    logic                        sat_q, sat_d;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [RND_W-1:0]     rounded;
    logic signed [RND_W-1:0]     shifted;
    logic [15:0]                 res_c;
    logic                        res_sat_c;

    // Result datapath: final sum including the incoming product, rounded and clamped.
    always_comb begin
        prod_ext  = ACC_WIDTH'($signed(prod_din));
        bias_ext  = ACC_WIDTH'($signed(bias)) <<< SHIFT;
        acc_sum   = acc_q + prod_ext;
        rounded   = RND_W'(acc_sum) + HALF;
        shifted   = rounded >>> SHIFT;
        res_sat_c = 1'b0;
        if (shifted > MAXV) begin
            res_c     = 16'h7fff;
            res_sat_c = 1'b1;
        end else if (shifted < MINV) begin
            res_c     = 16'h8000;
            res_sat_c = 1'b1;
        end else begin
            res_c = shifted[15:0];
        end
        if ((RELU != 0) && res_c[15]) begin
            res_c = 16'h0000;
        end
    end

    // Next-state and register-update logic for the IDLE/ACC/OUT window sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        sat_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prod_valid) begin
                    acc_d   = prod_ext + bias_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (prod_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(KERNEL_LEN - 1)) begin
                        cnt_d   = '0;
                        dout_d  = res_c;
                        sat_d   = res_sat_c;
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window or pending result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign prod_ready = (state_q != S_OUT);
    assign out_dout   = dout_q;
    assign out_valid  = valid_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_conv_3_5_mac_acc.sv
// Bench for conv_3_5_mac_acc: two instances (RELU=1 and RELU=0) share stimulus;
// expected pixels come from a behavioural model via per-instance queues.
module tb_conv_3_5_mac_acc;

    localparam int KL = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] prod_din;
    logic        prod_valid;
    logic [15:0] bias;
    logic        out_ready;

    logic        pr1, ov1, sat1;
    logic [15:0] od1;
    logic        pr0, ov0, sat0;
    logic [15:0] od0;

    typedef struct {
        logic [15:0] dout;
        logic        sat;
        logic        chk_sat;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    conv_3_5_mac_acc #(.KERNEL_LEN(KL), .IN_WIDTH(24), .ACC_WIDTH(32), .SHIFT(8), .RELU(1)) u_relu (
        .ap_clk(clk), .ap_rst_n(rst_n), .prod_din(prod_din), .prod_valid(prod_valid),
        .prod_ready(pr1), .bias(bias), .out_dout(od1), .out_valid(ov1),
        .out_ready(out_ready), .sat(sat1)
    );

    conv_3_5_mac_acc #(.KERNEL_LEN(KL), .IN_WIDTH(24), .ACC_WIDTH(32), .SHIFT(8), .RELU(0)) u_lin (
        .ap_clk(clk), .ap_rst_n(rst_n), .prod_din(prod_din), .prod_valid(prod_valid),
        .prod_ready(pr0), .bias(bias), .out_dout(od0), .out_valid(ov0),
        .out_ready(out_ready), .sat(sat0)
    );

    // Round-half-up, shift by 8, saturate to int16, then optional ReLU.
    function automatic exp_t model(input longint acc, input bit relu);
        exp_t   e;
        longint r;
        r     = (acc + 128) >>> 8;
        e.sat = 1'b0;
        if (r > 32767) begin
            r = 32767; e.sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; e.sat = 1'b1;
        end
        e.chk_sat = !(relu && e.sat && (r < 0));
        if (relu && (r < 0)) r = 0;
        e.dout = 16'(r);
        return e;
    endfunction

    task automatic push_exp(input longint acc);
        q1.push_back(model(acc, 1'b1));
        q0.push_back(model(acc, 1'b0));
    endtask

    task automatic send_window(input logic [15:0] b, input int n, input bit rnd,
                               input int cval, input bit bubbles, output longint acc);
        int v;
        int w;
        acc  = longint'($signed(b)) * 256;
        bias = b;
        for (int i = 0; i < n; i++) begin
            if (bubbles && ($urandom_range(0, 3) == 0)) begin
                prod_valid = 1'b0;
                prod_din   = 24'($urandom);
                @(posedge clk); #1;
            end
            v = rnd ? (int'($urandom_range(0, 16777215)) - 8388608) : cval;
            prod_din   = 24'(v);
            prod_valid = 1'b1;
            w = 0;
            while (!(pr1 && pr0) && (w < 20)) begin
                @(posedge clk); #1;
                w++;
            end
            if (w == 20) begin
                n_tests++; n_fail++;
                $display("FAIL prod_ready_timeout: prod_ready=%b/%b required 1", pr1, pr0);
            end
            @(posedge clk); #1;
            acc += longint'(v);
            if (rnd && (i == 0)) bias = 16'($urandom);
        end
        prod_valid = 1'b0;
        if (n == KL) begin
            n_tests++;
            if (ov1 !== 1'b1 || ov0 !== 1'b1) begin
                n_fail++;
                $display("FAIL latency: out_valid=%b/%b one cycle after last product, required 1", ov1, ov0);
            end
        end
    endtask

    task automatic check_output(input string name, input int hold);
        exp_t        e1, e0;
        logic [15:0] h1, h0;
        if (q1.size() == 0 || q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty, got out_valid=%b/%b", name, ov1, ov0);
            return;
        end
        e1 = q1.pop_front();
        e0 = q0.pop_front();
        n_tests++;
        if (ov1 !== 1'b1 || ov0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s valid: got %b/%b required 1", name, ov1, ov0);
        end
        n_tests++;
        if (od1 !== e1.dout) begin
            n_fail++;
            $display("FAIL %s relu1_dout: got %0d required %0d", name, $signed(od1), $signed(e1.dout));
        end
        n_tests++;
        if (od0 !== e0.dout) begin
            n_fail++;
            $display("FAIL %s relu0_dout: got %0d required %0d", name, $signed(od0), $signed(e0.dout));
        end
        if (e1.chk_sat) begin
            n_tests++;
            if (sat1 !== e1.sat) begin
                n_fail++;
                $display("FAIL %s relu1_sat: got %b required %b", name, sat1, e1.sat);
            end
        end
        n_tests++;
        if (sat0 !== e0.sat) begin
            n_fail++;
            $display("FAIL %s relu0_sat: got %b required %b", name, sat0, e0.sat);
        end
        h1 = od1;
        h0 = od0;
        if (hold > 0) begin
            out_ready  = 1'b0;
            prod_valid = 1'b1;
            prod_din   = 24'h123456;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                n_tests++;
                if (ov1 !== 1'b1 || ov0 !== 1'b1 || od1 !== h1 || od0 !== h0) begin
                    n_fail++;
                    $display("FAIL %s hold_stable: valid=%b/%b dout=%0d/%0d required 1/1 %0d/%0d",
                             name, ov1, ov0, $signed(od1), $signed(od0), $signed(h1), $signed(h0));
                end
                n_tests++;
                if (pr1 !== 1'b0 || pr0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s hold_prod_ready: got %b/%b required 0", name, pr1, pr0);
                end
                n_tests++;
                if (sat1 !== 1'b0 || sat0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s sat_pulse_width: got %b/%b required 0", name, sat1, sat0);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        n_tests++;
        if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_drop: got %b/%b required 0", name, ov1, ov0);
        end
        n_tests++;
        if (pr1 !== 1'b1 || pr0 !== 1'b1 || sat1 !== 1'b0 || sat0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_xfer: prod_ready=%b/%b sat=%b/%b required 1/1 0/0",
                     name, pr1, pr0, sat1, sat0);
        end
    endtask

    task automatic check_zeroed(input string name);
        n_tests++;
        if (ov1 !== 1'b0 || ov0 !== 1'b0 || od1 !== 16'd0 || od0 !== 16'd0 ||
            sat1 !== 1'b0 || sat0 !== 1'b0 || pr1 !== 1'b1 || pr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: valid=%b/%b dout=%0d/%0d sat=%b/%b ready=%b/%b required 0 0 0 1",
                     name, ov1, ov0, $signed(od1), $signed(od0), sat1, sat0, pr1, pr0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; prod_valid = 1'b0; prod_din = '0; bias = '0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_zeroed("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_zeroed("post_reset");
    endtask

    task automatic test_const(input string name, input logic [15:0] b, input int cval);
        longint acc;
        send_window(b, KL, 1'b0, cval, 1'b0, acc);
        push_exp(acc);
        check_output(name, 0);
    endtask

    task automatic test_bubbles();
        longint acc;
        for (int k = 0; k < 3; k++) begin
            send_window(16'($urandom), KL, 1'b1, 0, 1'b1, acc);
            push_exp(acc);
            check_output("random_bubbles", 0);
        end
    endtask

    task automatic test_backpressure();
        longint acc;
        send_window(16'd0, KL, 1'b0, 256, 1'b1, acc);
        push_exp(acc);
        check_output("backpressure", 5);
        test_const("after_backpressure", 16'd3, 128);
    endtask

    task automatic test_back_to_back();
        longint acc;
        send_window(16'hfffe, KL, 1'b0, 1000, 1'b0, acc);
        push_exp(acc);
        check_output("b2b_first", 0);
        send_window(16'd5, KL, 1'b0, -700, 1'b0, acc);
        push_exp(acc);
        check_output("b2b_second", 0);
    endtask

    task automatic test_reset_mid();
        longint acc;
        send_window(16'd7, 10, 1'b0, 256, 1'b0, acc);
        rst_n = 1'b0;
        #1 check_zeroed("reset_mid_window");
        @(posedge clk); #1 rst_n = 1'b1;
        test_const("after_reset_mid", 16'd0, 256);
        send_window(16'd0, KL, 1'b0, 256, 1'b0, acc);
        rst_n = 1'b0;
        #1 check_zeroed("reset_pending_out");
        @(posedge clk); #1 rst_n = 1'b1;
        test_const("after_reset_out", 16'd0, 256);
    endtask

    initial begin
        test_reset();
        test_const("basic_256", 16'd0, 256);
        test_const("bias3_128", 16'd3, 128);
        test_const("neg_256", 16'd0, -256);
        test_const("sat_pos", 16'd0, 8388607);
        test_const("sat_neg", 16'd0, -8388608);
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d left, required 0", q1.size(), q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
